// File: rtl/opcode_pkg.sv
// opcode_pkg: sequence table, index helpers and state type shared by the opcode checker files.
package opcode_pkg;
    localparam int OPC_W   = 4;
    localparam int SEQ_LEN = 9;
    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam logic [OPC_W-1:0] OPC_0 = 4'h2;
    localparam logic [OPC_W-1:0] OPC_1 = 4'h3;
    localparam logic [OPC_W-1:0] OPC_2 = 4'h0;
    localparam logic [OPC_W-1:0] OPC_3 = 4'h1;
    localparam logic [OPC_W-1:0] OPC_4 = 4'h7;
    localparam logic [OPC_W-1:0] OPC_5 = 4'h8;
    localparam logic [OPC_W-1:0] OPC_6 = 4'hA;
    localparam logic [OPC_W-1:0] OPC_7 = 4'hE;
    localparam logic [OPC_W-1:0] OPC_8 = 4'hF;
    localparam logic [SEQ_LEN-1:0][OPC_W-1:0] SEQ_TBL =
        {OPC_8, OPC_7, OPC_6, OPC_5, OPC_4, OPC_3, OPC_2, OPC_1, OPC_0};
    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(SEQ_LEN - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/opcode_seq_checker_if.sv
// opcode_seq_checker_if: stimulus and result signals of the opcode checker.
interface opcode_seq_checker_if #(
    parameter int CNT_W = 16
);
    import opcode_pkg::*;
    logic             en;
    logic             clr;
    logic [OPC_W-1:0] OPCODE;
    logic             locked;
    logic             err;
    logic             illegal;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] seq_count;
    modport master (output en, clr, OPCODE, input locked, err, illegal, err_count, seq_count);
    modport slave  (input en, clr, OPCODE, output locked, err, illegal, err_count, seq_count);
endinterface

// File: rtl/opcode_seq_lut.sv
// opcode_seq_lut: forward (index->opcode) and reverse (opcode->legal, index) sequence table lookup.
module opcode_seq_lut
    import opcode_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic [OPC_W-1:0] i_opc,
    output logic [OPC_W-1:0] o_opc,
    output logic             o_legal,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        o_opc   = '0;
        o_legal = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (i_idx == IDX_W'(k)) o_opc = SEQ_TBL[k];
            if (i_opc == SEQ_TBL[k]) begin
                o_legal = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/opcode_seq_checker.sv
// opcode_seq_checker: locks onto the 9-symbol opcode cycle, flags mismatches/illegal codes
// and keeps saturating error and completed-cycle counts.
module opcode_seq_checker
    import opcode_pkg::*;
#(
    parameter int LOCK_COUNT  = 3,
    parameter int LOSS_THRESH = 2,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    opcode_seq_checker_if.slave io_bus
);
    localparam int M_W = $clog2(LOCK_COUNT + 1);
    localparam int S_W = $clog2(LOSS_THRESH + 1);
    state_t           r_state;
    logic [IDX_W-1:0] r_exp_idx;
    logic [M_W-1:0]   r_match;
    logic [S_W-1:0]   r_miss;
    logic             r_locked, r_err, r_illegal;
    logic [CNT_W-1:0] r_err_count, r_seq_count;
    logic [OPC_W-1:0] w_exp_opc;
    logic             w_legal, w_hit;
    logic [IDX_W-1:0] w_pos;
    logic [M_W-1:0]   w_match_nx;
    logic [S_W-1:0]   w_miss_nx;
    opcode_seq_lut u_lut (
        .i_idx  (r_exp_idx),
        .i_opc  (io_bus.OPCODE),
        .o_opc  (w_exp_opc),
        .o_legal(w_legal),
        .o_idx  (w_pos)
    );
    assign w_hit      = io_bus.OPCODE == w_exp_opc;
    assign w_match_nx = r_match + 1'b1;
    assign w_miss_nx  = r_miss + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEARCH;
            r_exp_idx   <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_illegal   <= 1'b0;
            r_err_count <= '0;
            r_seq_count <= '0;
        end else begin
            r_err     <= 1'b0;
            r_illegal <= io_bus.en && !w_legal;
            if (io_bus.en) begin
                if (r_state == LOCKED) begin
                    // index advances even on a miss so one corrupted symbol keeps alignment
                    r_exp_idx <= next_idx(r_exp_idx);
                    r_miss    <= w_hit ? '0 : w_miss_nx;
                    if (w_hit && r_exp_idx == IDX_W'(SEQ_LEN - 1) && !(&r_seq_count))
                        r_seq_count <= r_seq_count + 1'b1;
                    if (!w_hit) begin
                        r_err <= 1'b1;
                        if (!(&r_err_count)) r_err_count <= r_err_count + 1'b1;
                        if (w_miss_nx == S_W'(LOSS_THRESH)) begin
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                            r_miss   <= '0;
                        end
                    end
                end else if (r_state == CONFIRM && w_hit) begin
                    r_exp_idx <= next_idx(r_exp_idx);
                    r_match   <= w_match_nx;
                    if (w_match_nx == M_W'(LOCK_COUNT)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end else if (w_legal) begin
                    r_exp_idx <= next_idx(w_pos);
                    r_match   <= M_W'(1);
                    r_state   <= (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
                    r_locked  <= LOCK_COUNT == 1;
                end else begin
                    r_state <= SEARCH;
                end
            end
            if (io_bus.clr) begin
                r_err_count <= '0;
                r_seq_count <= '0;
            end
        end
    end
    assign io_bus.locked    = r_locked;
    assign io_bus.err       = r_err;
    assign io_bus.illegal   = r_illegal;
    assign io_bus.err_count = r_err_count;
    assign io_bus.seq_count = r_seq_count;
endmodule

// File: tb/tb_opcode_seq_checker.sv
// tb_opcode_seq_checker: directed and random opcode streams against a behavioural model,
// driving a 16-bit-counter and a 2-bit-counter checker with the same stream.
module tb_opcode_seq_checker;
    localparam int LOCK = 3;
    localparam int LOSS = 2;
    int seq_tbl [9] = '{2, 3, 0, 1, 7, 8, 10, 14, 15};
    logic clk = 1'b0, rst_n = 1'b0;
    logic t_en = 1'b0, t_clr = 1'b0;
    logic [3:0] t_opc = 4'h0;
    int n_checks = 0, n_fail = 0;
    opcode_seq_checker_if #(.CNT_W(16)) bus_w ();
    opcode_seq_checker_if #(.CNT_W(2))  bus_n ();
    assign bus_w.en = t_en;
    assign bus_w.clr = t_clr;
    assign bus_w.OPCODE = t_opc;
    assign bus_n.en = t_en;
    assign bus_n.clr = t_clr;
    assign bus_n.OPCODE = t_opc;
    opcode_seq_checker #(.LOCK_COUNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .io_bus(bus_w));
    opcode_seq_checker #(.LOCK_COUNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .io_bus(bus_n));
    always #5 clk = ~clk;
    // model: m_run = consecutive in-sequence symbols seen while unlocked (0 = searching)
    bit m_lock, m_err, m_ill;
    int m_run, m_pos, m_miss, m_errs, m_seqs;
    function automatic int find(input int o);
        for (int k = 0; k < 9; k++) if (seq_tbl[k] == o) return k;
        return -1;
    endfunction
    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction
    task automatic model_reset();
        m_lock = 0; m_err = 0; m_ill = 0;
        m_run = 0; m_pos = 0; m_miss = 0; m_errs = 0; m_seqs = 0;
    endtask
    task automatic model_step(input bit e, input bit c, input int o);
        int p;
        p = find(o);
        m_err = 0;
        m_ill = 0;
        if (e) begin
            m_ill = (p < 0);
            if (m_lock) begin
                if (o == seq_tbl[m_pos]) begin
                    m_miss = 0;
                    if (m_pos == 8) m_seqs++;
                end else begin
                    m_err = 1;
                    m_errs++;
                    m_miss++;
                    if (m_miss == LOSS) begin m_lock = 0; m_run = 0; m_miss = 0; end
                end
                m_pos = (m_pos + 1) % 9;
            end else if (m_run > 0 && o == seq_tbl[m_pos]) begin
                m_run++;
                m_pos = (m_pos + 1) % 9;
                if (m_run == LOCK) m_lock = 1;
            end else if (p >= 0) begin
                m_run = 1;
                m_pos = (p + 1) % 9;
                m_lock = (LOCK == 1);
            end else begin
                m_run = 0;
            end
        end
        if (c) begin m_errs = 0; m_seqs = 0; end
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    always @(posedge clk) if (rst_n) model_step(t_en, t_clr, int'(t_opc));
    always @(negedge clk) if (rst_n) begin
        chk("locked", bus_w.locked, m_lock);
        chk("err", bus_w.err, m_err);
        chk("illegal", bus_w.illegal, m_ill);
        chk("err_count", bus_w.err_count, sat(m_errs, 16));
        chk("seq_count", bus_w.seq_count, sat(m_seqs, 16));
        chk("n_locked", bus_n.locked, m_lock);
        chk("n_err", bus_n.err, m_err);
        chk("n_err_count", bus_n.err_count, sat(m_errs, 2));
        chk("n_seq_count", bus_n.seq_count, sat(m_seqs, 2));
    end
    task automatic cyc(input bit e, input bit c, input int o);
        t_en = e; t_clr = c; t_opc = 4'(o);
        @(posedge clk); #1;
    endtask
    task automatic send(input int o);
        cyc(1, 0, o);
    endtask
    task automatic send_cycle();
        for (int k = 0; k < 9; k++) send(seq_tbl[k]);
    endtask
    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask
    initial begin
        int pos, r, o;
        bit e, c;
        model_reset();
        do_reset();
        chk("rst_locked", bus_w.locked, 0);
        chk("rst_err_count", bus_w.err_count, 0);
        chk("rst_seq_count", bus_w.seq_count, 0);
        send(2); send(3);
        chk("not_locked_after_2", bus_w.locked, 0);
        send(0);
        chk("locked_after_3", bus_w.locked, 1);
        for (int k = 3; k < 9; k++) send(seq_tbl[k]);
        send_cycle(); send_cycle();
        chk("seq_count_3", bus_w.seq_count, 3);
        chk("err_count_0", bus_w.err_count, 0);
        send(2); send(3); send(0); send(1); send(9);
        chk("corrupt_err", bus_w.err, 1);
        chk("corrupt_illegal", bus_w.illegal, 1);
        chk("corrupt_err_count", bus_w.err_count, 1);
        chk("corrupt_locked", bus_w.locked, 1);
        send(8);
        chk("realign_err", bus_w.err, 0);
        send(10); send(14); send(15);
        chk("seq_count_4", bus_w.seq_count, 4);
        send(2); send(3); send(0); send(1); send(7); send(5);
        chk("loss1_err_count", bus_w.err_count, 2);
        chk("loss1_locked", bus_w.locked, 1);
        send(5);
        chk("loss2_err", bus_w.err, 1);
        chk("loss2_err_count", bus_w.err_count, 3);
        chk("loss2_locked", bus_w.locked, 0);
        send(2); send(3);
        chk("relock_pending", bus_w.locked, 0);
        send(0);
        chk("relocked", bus_w.locked, 1);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        chk("hold_locked", bus_w.locked, 1);
        chk("hold_err", bus_w.err, 0);
        chk("hold_err_count", bus_w.err_count, 3);
        for (int k = 3; k < 9; k++) send(seq_tbl[k]);
        chk("hold_no_err", bus_w.err_count, 3);
        chk("seq_count_5", bus_w.seq_count, 5);
        cyc(1, 1, 2);
        chk("clr_err_count", bus_w.err_count, 0);
        chk("clr_seq_count", bus_n.seq_count, 0);
        send(4); send(0); send(12); send(7); send(13); send(10); send(11); send(15);
        chk("sat_n_err_count", bus_n.err_count, 3);
        chk("wide_err_count_4", bus_w.err_count, 4);
        chk("alt_locked", bus_w.locked, 1);
        cyc(1, 1, 4);
        chk("clr_vs_inc_err", bus_w.err, 1);
        chk("clr_vs_inc_w", bus_w.err_count, 0);
        chk("clr_vs_inc_n", bus_n.err_count, 0);
        send(3); send(0); send(1); send(7); send(8); send(10); send(14); send(15);
        chk("pre_rst_seq", bus_w.seq_count, 1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("async_locked", bus_w.locked, 0);
        chk("async_seq_count", bus_w.seq_count, 0);
        @(posedge clk); #1;
        rst_n = 1;
        send(14); send(15);
        chk("mid_confirm", bus_w.locked, 0);
        send(2);
        chk("mid_locked", bus_w.locked, 1);
        chk("mid_seq_0", bus_w.seq_count, 0);
        for (int k = 1; k < 9; k++) send(seq_tbl[k]);
        chk("mid_seq_1", bus_w.seq_count, 1);
        pos = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(99));
            e = ($urandom_range(9) != 0);
            c = e && ($urandom_range(49) == 0);
            if (r < 6) o = int'($urandom_range(15));
            else begin
                if (r < 9) pos = int'($urandom_range(8));
                o = seq_tbl[pos];
            end
            cyc(e, c, o);
            if (e) pos = (pos + 1) % 9;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
